// File: rtl/sm_to_c2_serial_pkg.sv
// Shared definitions for the bit-serial sign/magnitude -> two's complement
// converter: FSM state encoding and the counter width helper.
package sm_to_c2_serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit counter wide enough to hold 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/c2_serial_neg_step.sv
// One LSB-first negation step. Two's complement negation serially is:
// copy bits up to and including the first 1, invert everything above it.
// Ports:
//   b        in  current magnitude bit
//   sgn      in  1 = negate
//   seen1    in  a 1 has already passed through at a lower bit position
//   zb       out result bit
//   seen1_nx out updated seen-a-one flag
module c2_serial_neg_step (
    input  logic b,
    input  logic sgn,
    input  logic seen1,
    output logic zb,
    output logic seen1_nx
);
    assign zb       = sgn ? (b ^ seen1) : b;
    assign seen1_nx = seen1 | b;
endmodule

// File: rtl/sm_to_c2_serial.sv
// Bit-serial sign/magnitude -> two's complement converter, one bit per clock,
// LSB first, with an soc/eoc handshake toward the consumer.
// Ports:
//   clock  in  rising-edge clock
//   reset_ in  asynchronous active-low reset
//   soc    in  start of conversion, held by consumer until eoc drops
//   s      in  sign (1 = negative)
//   m      in  N-bit unsigned magnitude
//   eoc    out end of conversion / idle
//   z      out N-bit two's complement result (updates only when eoc rises)
//   ovf    out result not representable in N bits
module sm_to_c2_serial
    import sm_to_c2_serial_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         soc,
    input  logic         s,
    input  logic [N-1:0] m,
    output logic         eoc,
    output logic [N-1:0] z,
    output logic         ovf
);
    localparam int CW = cnt_w(N);

    state_t        state, state_nx;
    logic [N-1:0]  sh, r;
    logic [CW-1:0] cnt;
    logic          sgn, seen1, ovf_n;
    logic          zb, seen1_nx;
    logic          last_bit;
    logic          ovf_rule;

    assign last_bit = (cnt == CW'(N - 1));

    // Positive values need MSB clear; negative values may reach exactly -2^(N-1).
    assign ovf_rule = m[N-1] & ~(s & (m[N-2:0] == '0));

    c2_serial_neg_step u_step (
        .b        (sh[0]),
        .sgn      (sgn),
        .seen1    (seen1),
        .zb       (zb),
        .seen1_nx (seen1_nx)
    );

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (soc)      state_nx = S_CONV;
            S_CONV:  if (last_bit) state_nx = S_DONE;
            // Waiting for soc low here is what prevents a retrigger in IDLE.
            S_DONE:  if (!soc)     state_nx = S_IDLE;
            default:               state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            sh    <= '0;
            r     <= '0;
            cnt   <= '0;
            sgn   <= 1'b0;
            seen1 <= 1'b0;
            ovf_n <= 1'b0;
            eoc   <= 1'b1;
            z     <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (soc) begin
                        sh    <= m;
                        sgn   <= s;
                        cnt   <= '0;
                        seen1 <= 1'b0;
                        ovf_n <= ovf_rule;
                        eoc   <= 1'b0;
                    end
                end
                S_CONV: begin
                    seen1 <= seen1_nx;
                    sh    <= sh >> 1;
                    r     <= {zb, r[N-1:1]};
                    cnt   <= cnt + 1'b1;
                end
                S_DONE: begin
                    if (!soc) begin
                        z   <= r;
                        ovf <= ovf_n;
                        eoc <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_to_c2_serial.sv
module tb_sm_to_c2_serial;
    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset_;
    logic         soc;
    logic         s;
    logic [N-1:0] m;
    logic         eoc;
    logic [N-1:0] z;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    sm_to_c2_serial #(.N(N)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .soc    (soc),
        .s      (s),
        .m      (m),
        .eoc    (eoc),
        .z      (z),
        .ovf    (ovf)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full handshake; returns number of edges from soc drop to eoc=1.
    task automatic conv(input logic s_i, input logic [N-1:0] m_i, output int lat);
        int n;
        @(negedge clock);
        soc = 1'b1; s = s_i; m = m_i;
        n = 0;
        do begin
            @(negedge clock); n++;
        end while (eoc && n < 10);
        check("eoc_fall_timeout", 32'(eoc), 32'd0);
        soc = 1'b0;
        n = 0;
        do begin
            @(negedge clock); n++;
        end while (!eoc && n < 20);
        check("eoc_rise_timeout", 32'(eoc), 32'd1);
        lat = n;
    endtask

    task automatic expect_res(input string tag, input logic [N-1:0] ze, input logic oe);
        check({tag, "_z"}, 32'(z), 32'(ze));
        check({tag, "_ovf"}, 32'(ovf), 32'(oe));
    endtask

    initial begin
        int lat;
        logic [N-1:0] ze;
        logic oe;
        logic [N-1:0] absz;

        soc = 1'b0; s = 1'b0; m = '0;
        reset_ = 1'b0;
        #12;
        check("rst_eoc", 32'(eoc), 32'd1);
        check("rst_z", 32'(z), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clock); reset_ = 1'b1;

        // T2: basic conversions and latency
        conv(1'b1, 4'b0011, lat);
        check("t2_lat", 32'(lat), 32'(N + 1));
        expect_res("t2_neg3", 4'b1101, 1'b0);
        conv(1'b0, 4'b0101, lat);
        check("t2_lat2", 32'(lat), 32'(N + 1));
        expect_res("t2_pos5", 4'b0101, 1'b0);

        // T1: reset mid-conversion clears outputs asynchronously
        @(negedge clock);
        soc = 1'b1; s = 1'b1; m = 4'b0110;
        @(negedge clock); soc = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("t1_busy", 32'(eoc), 32'd0);
        #2 reset_ = 1'b0;
        #1;
        check("t1_eoc", 32'(eoc), 32'd1);
        check("t1_z", 32'(z), 32'd0);
        check("t1_ovf", 32'(ovf), 32'd0);
        @(negedge clock); reset_ = 1'b1;
        repeat (8) @(negedge clock);
        check("t1_no_partial", 32'(z), 32'd0);
        conv(1'b1, 4'b0110, lat);
        expect_res("t1_restart", 4'b1010, 1'b0);

        // T3: boundaries
        conv(1'b1, 4'b0000, lat); expect_res("t3_negzero", 4'b0000, 1'b0);
        conv(1'b1, 4'b1000, lat); expect_res("t3_most_neg", 4'b1000, 1'b0);
        conv(1'b0, 4'b1000, lat); expect_res("t3_pos8", 4'b1000, 1'b1);
        conv(1'b1, 4'b1001, lat); expect_res("t3_neg9", 4'b0111, 1'b1);

        // T4: soc held high well past the conversion
        @(negedge clock);
        soc = 1'b1; s = 1'b0; m = 4'b0010;
        @(negedge clock);
        repeat (10) @(negedge clock);
        check("t4_eoc_held", 32'(eoc), 32'd0);
        check("t4_z_kept", 32'(z), 32'b0111);
        soc = 1'b0;
        @(negedge clock);
        check("t4_eoc_next", 32'(eoc), 32'd1);
        expect_res("t4_res", 4'b0010, 1'b0);

        // T5: inputs changed during conversion are ignored
        @(negedge clock);
        soc = 1'b1; s = 1'b1; m = 4'b0001;
        @(negedge clock);
        soc = 1'b0; s = 1'b0; m = 4'b1111;
        lat = 0;
        do begin
            @(negedge clock); lat++;
        end while (!eoc && lat < 20);
        check("t5_eoc", 32'(eoc), 32'd1);
        expect_res("t5_res", 4'b1111, 1'b0);

        // T6: exhaustive sweep
        for (int i = 0; i < 32; i++) begin
            logic       si;
            logic [N-1:0] mi;
            si = i[4];
            mi = i[3:0];
            ze = si ? 4'(-mi) : mi;
            oe = mi[3] & ~(si & (mi[2:0] == 3'b000));
            conv(si, mi, lat);
            check("t6_lat", 32'(lat), 32'(N + 1));
            expect_res($sformatf("t6_s%0d_m%0d", si, mi), ze, oe);
            if (!oe) begin
                absz = z[N-1] ? 4'(-z) : z;
                check("t6_abs", 32'(absz), 32'(mi));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
